// File: rtl/seg_pkg.sv
// Shared types and constants for the scrolling 7-segment sequencer.
package seg_pkg;

  localparam int unsigned CODE_W     = 5;
  localparam int unsigned MAX_DIGITS = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // All-ones digit-enable pattern (every digit dark) for n digits.
  function automatic logic [MAX_DIGITS-1:0] blank_an(input int unsigned n);
    blank_an = MAX_DIGITS'((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/seg_scroll_ctrl_tick_prescaler.sv
// Free-running divide-by-DIV counter producing a one-cycle tick on its last count.
module tick_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_c_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_c_o = en_i && !clr_i && (cnt_q == LAST);

  // Next count: clear wins, otherwise count and wrap on the tick.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_c_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Multiplexed-digit scanner with a scrolling message window feeding one shared decoder.
module seg_scroll_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned MSG_LEN       = 16,
  parameter int unsigned SCAN_DIV      = 50000,
  parameter int unsigned SCROLL_FRAMES = 100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  input  logic                       hold,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [CODE_W-1:0]          wr_code,
  output logic [CODE_W-1:0]          code_out,
  output logic [NUM_DIGITS-1:0]      an,
  output logic                       frame_tick,
  output logic                       scroll_tick
);

  localparam int unsigned AW = $clog2(MSG_LEN);
  localparam int unsigned DW = $clog2(NUM_DIGITS);
  localparam int unsigned FW = $clog2(SCROLL_FRAMES + 1);
  localparam logic [DW-1:0] LAST_D = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] LAST_F = FW'(SCROLL_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] BLANK_AN = NUM_DIGITS'(blank_an(NUM_DIGITS));

  state_e              state_q, state_d;
  logic [DW-1:0]       d_q, d_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic [AW-1:0]       offset_q, offset_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                frame_tick_q, frame_tick_d;
  logic                scroll_tick_q, scroll_tick_d;
  logic                load;
  logic                scan_tick;
  logic                scan_en;
  logic                scan_clr;
  logic [CODE_W-1:0]   msg_q [MSG_LEN];

  assign scan_en  = (state_q == ST_RUN);
  assign scan_clr = !((state_q == ST_RUN) && run);

  tick_prescaler #(
    .DIV (SCAN_DIV)
  ) u_scan_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (scan_en),
    .clr_i    (scan_clr),
    .tick_c_o (scan_tick)
  );

  // Message buffer; reads elsewhere see the pre-write value on a same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_q[i] <= '0;
      end
    end else if (wr_en) begin
      msg_q[wr_addr] <= wr_code;
    end
  end

  // Next-state: scan stepping, frame/scroll counting, clear override, output load.
  always_comb begin
    state_d       = state_q;
    d_d           = d_q;
    fcnt_d        = fcnt_q;
    offset_d      = offset_q;
    an_d          = an_q;
    code_d        = code_q;
    frame_tick_d  = 1'b0;
    scroll_tick_d = 1'b0;
    load          = 1'b0;

    if (state_q == ST_IDLE) begin
      d_d    = '0;
      fcnt_d = '0;
      an_d   = BLANK_AN;
      code_d = '0;
      if (run) begin
        state_d = ST_RUN;
        load    = 1'b1;
      end
    end else if (!run) begin
      state_d = ST_IDLE;
      d_d     = '0;
      fcnt_d  = '0;
      an_d    = BLANK_AN;
      code_d  = '0;
    end else if (scan_tick) begin
      load = 1'b1;
      if (d_q == LAST_D) begin
        d_d          = '0;
        frame_tick_d = 1'b1;
        if (!hold) begin
          if (fcnt_q == LAST_F) begin
            fcnt_d        = '0;
            offset_d      = offset_q + AW'(1);
            scroll_tick_d = 1'b1;
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end
      end else begin
        d_d = d_q + DW'(1);
      end
    end

    if (clear) begin
      offset_d      = '0;
      fcnt_d        = '0;
      scroll_tick_d = 1'b0;
    end

    // A new offset only reaches the display at the next slot load, so frames never split.
    if (load) begin
      an_d   = ~(NUM_DIGITS'(1) << d_d);
      code_d = msg_q[offset_d + AW'(d_d)];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      d_q           <= '0;
      fcnt_q        <= '0;
      offset_q      <= '0;
      an_q          <= BLANK_AN;
      code_q        <= '0;
      frame_tick_q  <= 1'b0;
      scroll_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      d_q           <= d_d;
      fcnt_q        <= fcnt_d;
      offset_q      <= offset_d;
      an_q          <= an_d;
      code_q        <= code_d;
      frame_tick_q  <= frame_tick_d;
      scroll_tick_q <= scroll_tick_d;
    end
  end

  assign code_out    = code_q;
  assign an          = an_q;
  assign frame_tick  = frame_tick_q;
  assign scroll_tick = scroll_tick_q;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Self-checking bench for seg_scroll_ctrl against a slot/frame-level reference model.
module tb_seg_scroll_ctrl;

  localparam int ND = 4;
  localparam int ML = 8;
  localparam int SD = 4;
  localparam int SF = 2;
  localparam int FRAME = ND * SD;

  logic       clk;
  logic       rst_n;
  logic       run, hold, clear, wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_code;
  logic [4:0] code_out;
  logic [3:0] an;
  logic       frame_tick, scroll_tick;

  int checks;
  int failures;

  // Reference model state: message, offset, cycles since entering RUN, frames since last step.
  int   m_msg [ML];
  int   m_off;
  int   m_t;
  int   m_frames;
  bit   m_run;
  logic [3:0] exp_an;
  logic [4:0] exp_code;
  logic exp_ft, exp_st;

  seg_scroll_ctrl #(
    .NUM_DIGITS    (ND),
    .MSG_LEN       (ML),
    .SCAN_DIV      (SD),
    .SCROLL_FRAMES (SF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .hold        (hold),
    .clear       (clear),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_code     (wr_code),
    .code_out    (code_out),
    .an          (an),
    .frame_tick  (frame_tick),
    .scroll_tick (scroll_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < ML; i++) m_msg[i] = 0;
    m_off = 0; m_t = 0; m_frames = 0; m_run = 0;
    exp_an = 4'hF; exp_code = 5'd0; exp_ft = 1'b0; exp_st = 1'b0;
  endtask

  // Predict the outputs after one clock edge from the inputs present at that edge.
  task automatic model_edge();
    int d;
    exp_ft = 1'b0;
    exp_st = 1'b0;
    if (!m_run) begin
      m_frames = 0;
      if (clear) m_off = 0;
      if (run) begin
        m_run = 1; m_t = 0;
        exp_an = 4'b1110;
        exp_code = 5'(m_msg[m_off]);
      end else begin
        exp_an = 4'hF; exp_code = 5'd0;
      end
    end else if (!run) begin
      m_run = 0; m_frames = 0;
      if (clear) m_off = 0;
      exp_an = 4'hF; exp_code = 5'd0;
    end else begin
      m_t++;
      if (m_t % SD == 0) begin
        d = (m_t / SD) % ND;
        if (d == 0) begin
          exp_ft = 1'b1;
          if (!hold) begin
            m_frames++;
            if (m_frames == SF) begin
              m_frames = 0;
              m_off = (m_off + 1) % ML;
              exp_st = 1'b1;
            end
          end
        end
        if (clear) begin m_off = 0; m_frames = 0; exp_st = 1'b0; end
        exp_an = ~(4'(1) << d);
        exp_code = 5'(m_msg[(m_off + d) % ML]);
      end else if (clear) begin
        m_off = 0; m_frames = 0;
      end
    end
    if (wr_en) m_msg[wr_addr] = int'(wr_code);
  endtask

  // One clock: inputs already driven, update model at the edge, return at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 0; hold = 0; clear = 0; wr_en = 0; wr_addr = '0; wr_code = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({an, code_out, frame_tick, scroll_tick} !== {4'hF, 5'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got an=%b code=%0d ft=%b st=%b want an=1111 code=0 ft=0 st=0",
               an, code_out, frame_tick, scroll_tick);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cycle();
      checks++;
      if ({an, code_out, frame_tick, scroll_tick} !== {4'hF, 5'd0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL idle_blank k=%0d got an=%b code=%0d ft=%b st=%b", k, an, code_out, frame_tick, scroll_tick);
      end
    end
    // Load msg = 0..7 while idle.
    for (int a = 0; a < ML; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_code = 5'(a);
      cycle();
    end
    wr_en = 1'b0;
    cycle();
    checks++;
    if ({an, code_out} !== {4'hF, 5'd0}) begin
      failures++;
      $display("FAIL idle_after_load got an=%b code=%0d want an=1111 code=0", an, code_out);
    end
  endtask

  task automatic test_scan();
    logic [3:0] w_an;
    run = 1'b1;
    for (int k = 0; k <= FRAME; k++) begin
      cycle();
      w_an = ~(4'(1) << ((k / SD) % ND));
      checks++;
      if ({an, code_out, frame_tick} !== {w_an, 5'((k / SD) % ND), (k == FRAME)}) begin
        failures++;
        $display("FAIL scan k=%0d got an=%b code=%0d ft=%b want an=%b code=%0d ft=%b",
                 k, an, code_out, frame_tick, w_an, (k / SD) % ND, (k == FRAME));
      end
    end
  endtask

  task automatic test_scroll();
    int steps;
    steps = 0;
    for (int k = 0; k < 12 * SF * FRAME && steps < ML; k++) begin
      cycle();
      checks++;
      if ({an, code_out, frame_tick, scroll_tick} !== {exp_an, exp_code, exp_ft, exp_st}) begin
        failures++;
        $display("FAIL scroll_model k=%0d got an=%b code=%0d ft=%b st=%b want an=%b code=%0d ft=%b st=%b",
                 k, an, code_out, frame_tick, scroll_tick, exp_an, exp_code, exp_ft, exp_st);
      end
      if (scroll_tick === 1'b1) begin
        steps++;
        checks++;
        if ({an, code_out} !== {4'b1110, 5'(steps % ML)}) begin
          failures++;
          $display("FAIL scroll_step n=%0d got an=%b code=%0d want an=1110 code=%0d",
                   steps, an, code_out, steps % ML);
        end
      end
    end
    checks++;
    if (steps != ML) begin
      failures++;
      $display("FAIL scroll_count got %0d steps want %0d", steps, ML);
    end
  endtask

  task automatic test_hold_clear();
    int st_seen;
    bit done;
    st_seen = 0;
    hold = 1'b1;
    for (int k = 0; k < 5 * FRAME; k++) begin
      cycle();
      if (scroll_tick === 1'b1) st_seen++;
      if (frame_tick === 1'b1) begin
        checks++;
        if (code_out !== 5'd0) begin
          failures++;
          $display("FAIL hold_offset k=%0d got code=%0d want 0", k, code_out);
        end
      end
    end
    checks++;
    if (st_seen != 0) begin
      failures++;
      $display("FAIL hold_no_scroll got %0d scroll ticks want 0", st_seen);
    end
    hold = 1'b0;
    done = 0;
    for (int k = 0; k < 3 * SF * FRAME && !done; k++) begin
      if (m_run && ((m_t + 1) % FRAME == 0) && (m_frames == SF - 1)) begin
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        done = 1;
        checks++;
        if ({an, code_out, frame_tick, scroll_tick} !== {4'b1110, 5'd0, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL clear_beats_step got an=%b code=%0d ft=%b st=%b want an=1110 code=0 ft=1 st=0",
                   an, code_out, frame_tick, scroll_tick);
        end
      end else begin
        cycle();
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL clear_timeout got no due scroll step want one");
    end
  endtask

  task automatic test_live_write();
    bit seen;
    seen = 0;
    for (int k = 0; k < 2 * FRAME && !seen; k++) begin
      cycle();
      if (an === 4'b1101) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL live_wait1 got an=%b want 1101", an);
    end
    wr_en = 1'b1; wr_addr = 3'd2; wr_code = 5'd21;
    cycle();
    wr_en = 1'b0;
    checks++;
    if ({an, code_out} !== {4'b1101, 5'd1}) begin
      failures++;
      $display("FAIL live_cur_slot got an=%b code=%0d want an=1101 code=1", an, code_out);
    end
    seen = 0;
    for (int k = 0; k < FRAME && !seen; k++) begin
      cycle();
      if (an === 4'b1011) seen = 1;
    end
    checks++;
    if (!seen || code_out !== 5'd21) begin
      failures++;
      $display("FAIL live_next_slot got an=%b code=%0d want an=1011 code=21", an, code_out);
    end
    // Same-edge write and load of address 3: the old value is shown.
    for (int k = 0; k < SD && (m_t % SD) != SD - 1; k++) cycle();
    wr_en = 1'b1; wr_addr = 3'd3; wr_code = 5'd9;
    cycle();
    wr_en = 1'b0;
    checks++;
    if ({an, code_out} !== {4'b0111, 5'd3}) begin
      failures++;
      $display("FAIL same_edge_write got an=%b code=%0d want an=0111 code=3", an, code_out);
    end
    cycle();
    checks++;
    if ({an, code_out} !== {exp_an, exp_code}) begin
      failures++;
      $display("FAIL live_model got an=%b code=%0d want an=%b code=%0d", an, code_out, exp_an, exp_code);
    end
  endtask

  task automatic test_stop_reset();
    int saved;
    for (int k = 0; k < 2 * SD && (m_t % SD) != 1; k++) cycle();
    saved = m_off;
    run = 1'b0;
    cycle();
    checks++;
    if ({an, code_out} !== {4'hF, 5'd0}) begin
      failures++;
      $display("FAIL stop_blank got an=%b code=%0d want an=1111 code=0", an, code_out);
    end
    repeat (3) cycle();
    run = 1'b1;
    cycle();
    checks++;
    if ({an, code_out} !== {4'b1110, 5'(m_msg[saved])}) begin
      failures++;
      $display("FAIL restart got an=%b code=%0d want an=1110 code=%0d", an, code_out, m_msg[saved]);
    end
    repeat (SD + 1) cycle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, code_out, frame_tick, scroll_tick} !== {4'hF, 5'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got an=%b code=%0d ft=%b st=%b want an=1111 code=0 ft=0 st=0",
               an, code_out, frame_tick, scroll_tick);
    end
    model_reset();
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 800; k++) begin
      run     = ($urandom_range(0, 19) != 0);
      hold    = ($urandom_range(0, 4) == 0);
      clear   = ($urandom_range(0, 29) == 0);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, ML - 1));
      wr_code = 5'($urandom_range(0, 31));
      cycle();
      checks++;
      if ({an, code_out, frame_tick, scroll_tick} !== {exp_an, exp_code, exp_ft, exp_st}) begin
        failures++;
        $display("FAIL random k=%0d got an=%b code=%0d ft=%b st=%b want an=%b code=%0d ft=%b st=%b",
                 k, an, code_out, frame_tick, scroll_tick, exp_an, exp_code, exp_ft, exp_st);
      end
    end
    run = 0; hold = 0; clear = 0; wr_en = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_scan();
    test_scroll();
    test_hold_clear();
    test_live_write();
    test_stop_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
